// File: rtl/mha_sa_pkg.sv
// Shared types for the systolic-array skew feeder: FSM state encoding and default lane width.
package mha_sa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    FLUSH,
    DONE
  } feeder_state_t;

  localparam int D_W_DEF = 16;

endpackage

// File: rtl/sa_skew_feeder_if.sv
// Controller <-> feeder handshake bundle. The feeder side uses the slave modport.
interface sa_skew_feeder_if
  import mha_sa_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int N   = 8,
  parameter int K_W = 10
);

  logic               I_START;
  logic [K_W-1:0]     I_K;
  logic               I_VLD;
  logic [N*D_W-1:0]   I_DATA;
  logic               O_RDY;
  logic [N-1:0]       O_VLD;
  logic [N*D_W-1:0]   O_DATA;
  logic               O_CLR;
  logic               O_BUSY;
  logic               O_DONE;

  modport slave (
    input  I_START, I_K, I_VLD, I_DATA,
    output O_RDY, O_VLD, O_DATA, O_CLR, O_BUSY, O_DONE
  );

  modport master (
    output I_START, I_K, I_VLD, I_DATA,
    input  O_RDY, O_VLD, O_DATA, O_CLR, O_BUSY, O_DONE
  );

endinterface

// File: rtl/skew_delay_line.sv
// Valid+data shift register of DEPTH stages; data is zeroed on entry when the slot is invalid.
module skew_delay_line
  import mha_sa_pkg::*;
#(
  parameter int D_W   = D_W_DEF,
  parameter int DEPTH = 1
) (
  input  logic                  I_CLK,
  input  logic                  I_ASYN_RSTN,
  input  logic                  I_SYNC_RSTN,
  input  logic                  i_vld,
  input  logic signed [D_W-1:0] i_data,
  output logic                  o_vld,
  output logic signed [D_W-1:0] o_data
);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic signed [D_W-1:0] data_q [DEPTH];
  logic signed [D_W-1:0] data_d [DEPTH];

  always_comb begin
    vld_d = '0;
    for (int k = 0; k < DEPTH; k++) begin
      data_d[k] = '0;
    end
    // Masking at the entry stage keeps every downstream invalid slot at zero.
    vld_d[0]  = i_vld;
    data_d[0] = i_vld ? i_data : '0;
    for (int k = 1; k < DEPTH; k++) begin
      vld_d[k]  = vld_q[k-1];
      data_d[k] = data_q[k-1];
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else if (!I_SYNC_RSTN) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign o_vld  = vld_q[DEPTH-1];
  assign o_data = data_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Systolic-array edge feeder: per tile clears the PEs, feeds K vectors with lane i delayed by
// i cycles, waits for the skew to drain, then pulses done.
module sa_skew_feeder
  import mha_sa_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int N   = 8,
  parameter int K_W = 10
) (
  input  logic            I_CLK,
  input  logic            I_ASYN_RSTN,
  input  logic            I_SYNC_RSTN,
  sa_skew_feeder_if.slave bus
);

  localparam int FL_W = $clog2(N);

  feeder_state_t     state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [K_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic              rdy_q, rdy_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept;
  logic [N-1:0]      lane_vld;
  logic [N*D_W-1:0]  lane_data;

  // O_RDY is registered and only ever high in FEED, so it doubles as the state qualifier.
  assign accept = bus.I_VLD & rdy_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.I_START) begin
          state_d    = CLR;
          k_d        = bus.I_K;
          beat_cnt_d = '0;
        end
      end
      CLR: begin
        state_d = (k_q != '0) ? FEED : DONE;
      end
      FEED: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + K_W'(1);
          if (beat_cnt_d == k_q) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        // The last beat reaches lane N-1's output after N cycles in FLUSH.
        if (flush_cnt_q == FL_W'(N-1)) begin
          state_d = DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rdy_d  = (state_d == FEED);
    clr_d  = (state_d == CLR);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= IDLE;
    end else if (!I_SYNC_RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      k_q         <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      rdy_q       <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      k_q         <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      rdy_q       <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      rdy_q       <= rdy_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .D_W   (D_W),
      .DEPTH (i + 1)
    ) u_delay (
      .I_CLK       (I_CLK),
      .I_ASYN_RSTN (I_ASYN_RSTN),
      .I_SYNC_RSTN (I_SYNC_RSTN),
      .i_vld       (accept),
      .i_data      (bus.I_DATA[i*D_W +: D_W]),
      .o_vld       (lane_vld[i]),
      .o_data      (lane_data[i*D_W +: D_W])
    );
  end

  assign bus.O_RDY  = rdy_q;
  assign bus.O_VLD  = lane_vld;
  assign bus.O_DATA = lane_data;
  assign bus.O_CLR  = clr_q;
  assign bus.O_BUSY = busy_q;
  assign bus.O_DONE = done_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder (N=4, D_W=16): cycle c is the cycle following clock edge c-1.
module tb_sa_skew_feeder;

  localparam int DW   = 16;
  localparam int NL   = 4;
  localparam int KW   = 10;
  localparam int MAXC = 32;

  logic clk;
  logic arst_n;
  logic srst_n;
  int   checks = 0;
  int   errors = 0;

  sa_skew_feeder_if #(.D_W(DW), .N(NL), .K_W(KW)) fif ();

  sa_skew_feeder #(.D_W(DW), .N(NL), .K_W(KW)) dut (
    .I_CLK       (clk),
    .I_ASYN_RSTN (arst_n),
    .I_SYNC_RSTN (srst_n),
    .bus         (fif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus per edge e, captured outputs per cycle c = e+1.
  logic          st_start [MAXC];
  logic [KW-1:0] st_k     [MAXC];
  logic          st_vld   [MAXC];
  logic [DW-1:0] st_dat   [MAXC];
  logic          st_srst  [MAXC];
  logic [NL-1:0] cap_vld  [MAXC];
  logic [DW-1:0] cap_dat  [MAXC][NL];
  logic          cap_clr  [MAXC];
  logic          cap_done [MAXC];
  logic          cap_rdy  [MAXC];
  logic          cap_busy [MAXC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fif.I_START = 1'b0;
    fif.I_K     = '0;
    fif.I_VLD   = 1'b0;
    fif.I_DATA  = '0;
    srst_n      = 1'b1;
  endtask

  task automatic clear_stim();
    for (int e = 0; e < MAXC; e++) begin
      st_start[e] = 1'b0;
      st_k[e]     = '0;
      st_vld[e]   = 1'b0;
      st_dat[e]   = '0;
      st_srst[e]  = 1'b0;
    end
  endtask

  // Lane j carries st_dat + j so lane swaps are visible.
  task automatic run_seq(input int len);
    for (int e = 0; e < len; e++) begin
      fif.I_START = st_start[e];
      fif.I_K     = st_k[e];
      fif.I_VLD   = st_vld[e];
      srst_n      = !st_srst[e];
      for (int j = 0; j < NL; j++) begin
        fif.I_DATA[j*DW +: DW] = st_dat[e] + 16'(j);
      end
      tick();
      cap_vld[e+1]  = fif.O_VLD;
      cap_clr[e+1]  = fif.O_CLR;
      cap_done[e+1] = fif.O_DONE;
      cap_rdy[e+1]  = fif.O_RDY;
      cap_busy[e+1] = fif.O_BUSY;
      for (int j = 0; j < NL; j++) begin
        cap_dat[e+1][j] = fif.O_DATA[j*DW +: DW];
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    arst_n      = 1'b0;
    srst_n      = 1'b1;
    fif.I_START = 1'b1;
    fif.I_K     = 10'd5;
    fif.I_VLD   = 1'b1;
    fif.I_DATA  = '1;
    tick();
    tick();
    checks++; if (fif.O_RDY !== 1'b0)  begin errors++; $display("FAIL reset_rdy: got %b exp 0", fif.O_RDY); end
    checks++; if (fif.O_VLD !== 4'b0)  begin errors++; $display("FAIL reset_vld: got %b exp 0000", fif.O_VLD); end
    checks++; if (fif.O_DATA !== '0)   begin errors++; $display("FAIL reset_data: got %h exp 0", fif.O_DATA); end
    checks++; if (fif.O_CLR !== 1'b0)  begin errors++; $display("FAIL reset_clr: got %b exp 0", fif.O_CLR); end
    checks++; if (fif.O_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", fif.O_BUSY); end
    checks++; if (fif.O_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", fif.O_DONE); end
    idle_inputs();
    arst_n = 1'b1;
    tick();
    tick();
    checks++; if (fif.O_BUSY !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b exp 0", fif.O_BUSY); end
    checks++; if (fif.O_CLR !== 1'b0)  begin errors++; $display("FAIL post_reset_clr: got %b exp 0", fif.O_CLR); end
    checks++; if (fif.O_RDY !== 1'b0)  begin errors++; $display("FAIL post_reset_rdy: got %b exp 0", fif.O_RDY); end
  endtask

  // K=3 tile with beats A,B,C; bubble variant skips edge 3. Junk valid data is offered in CLR
  // and FLUSH, and I_K is changed after start; none of it may take effect.
  task automatic test_feed(input bit bubble);
    string         nm;
    int            acc_e [3];
    logic [DW-1:0] acc_v [3];
    int            done_c;
    int            last_e;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    nm = bubble ? "bubble" : "basic";
    acc_v[0] = 16'h2000; acc_v[1] = 16'h1000; acc_v[2] = 16'hE000;
    if (bubble) begin
      acc_e[0] = 2; acc_e[1] = 4; acc_e[2] = 5; done_c = 10; last_e = 5;
    end else begin
      acc_e[0] = 2; acc_e[1] = 3; acc_e[2] = 4; done_c = 9;  last_e = 4;
    end
    clear_stim();
    st_start[0] = 1'b1;
    st_k[0]     = 10'd3;
    for (int e = 1; e < 13; e++) st_k[e] = 10'd7;
    st_vld[1] = 1'b1; st_dat[1] = 16'h5555;
    for (int b = 0; b < 3; b++) begin
      st_vld[acc_e[b]] = 1'b1;
      st_dat[acc_e[b]] = acc_v[b];
    end
    if (bubble) st_dat[3] = 16'h3333;
    st_vld[last_e+1] = 1'b1; st_dat[last_e+1] = 16'h7777;
    run_seq(13);
    for (int c = 1; c <= 13; c++) begin
      checks++; if (cap_clr[c] !== (c == 1))
        begin errors++; $display("FAIL %s clr c%0d: got %b exp %b", nm, c, cap_clr[c], (c == 1)); end
      checks++; if (cap_done[c] !== (c == done_c))
        begin errors++; $display("FAIL %s done c%0d: got %b exp %b", nm, c, cap_done[c], (c == done_c)); end
      checks++; if (cap_rdy[c] !== (c >= 2 && c <= last_e))
        begin errors++; $display("FAIL %s rdy c%0d: got %b exp %b", nm, c, cap_rdy[c], (c >= 2 && c <= last_e)); end
      checks++; if (cap_busy[c] !== (c <= done_c))
        begin errors++; $display("FAIL %s busy c%0d: got %b exp %b", nm, c, cap_busy[c], (c <= done_c)); end
      for (int i = 0; i < NL; i++) begin
        exp_v = 1'b0;
        exp_d = '0;
        for (int b = 0; b < 3; b++) begin
          if (c - 1 - i == acc_e[b]) begin
            exp_v = 1'b1;
            exp_d = acc_v[b] + 16'(i);
          end
        end
        checks++; if (cap_vld[c][i] !== exp_v)
          begin errors++; $display("FAIL %s lane%0d vld c%0d: got %b exp %b", nm, i, c, cap_vld[c][i], exp_v); end
        checks++; if (cap_dat[c][i] !== exp_d)
          begin errors++; $display("FAIL %s lane%0d data c%0d: got %h exp %h", nm, i, c, cap_dat[c][i], exp_d); end
      end
    end
  endtask

  task automatic test_k0();
    clear_stim();
    st_start[0] = 1'b1;
    st_k[0]     = 10'd0;
    for (int e = 0; e < 8; e++) begin
      st_vld[e] = 1'b1;
      st_dat[e] = 16'h4321;
    end
    run_seq(8);
    for (int c = 1; c <= 8; c++) begin
      checks++; if (cap_clr[c] !== (c == 1))
        begin errors++; $display("FAIL k0 clr c%0d: got %b exp %b", c, cap_clr[c], (c == 1)); end
      checks++; if (cap_done[c] !== (c == 2))
        begin errors++; $display("FAIL k0 done c%0d: got %b exp %b", c, cap_done[c], (c == 2)); end
      checks++; if (cap_rdy[c] !== 1'b0)
        begin errors++; $display("FAIL k0 rdy c%0d: got %b exp 0", c, cap_rdy[c]); end
      checks++; if (cap_busy[c] !== (c <= 2))
        begin errors++; $display("FAIL k0 busy c%0d: got %b exp %b", c, cap_busy[c], (c <= 2)); end
      checks++; if (cap_vld[c] !== 4'b0000)
        begin errors++; $display("FAIL k0 vld c%0d: got %b exp 0000", c, cap_vld[c]); end
      checks++; if (cap_dat[c][NL-1] !== 16'h0000)
        begin errors++; $display("FAIL k0 lane3 data c%0d: got %h exp 0000", c, cap_dat[c][NL-1]); end
    end
  endtask

  task automatic test_sync_reset();
    clear_stim();
    st_start[0] = 1'b1;
    st_k[0]     = 10'd3;
    for (int e = 2; e < 9; e++) begin
      st_vld[e] = 1'b1;
      st_dat[e] = 16'h1234;
    end
    st_dat[2]  = 16'h2000;
    st_srst[3] = 1'b1;
    run_seq(12);
    checks++; if (cap_vld[3] !== 4'b0001)
      begin errors++; $display("FAIL srst pre vld c3: got %b exp 0001", cap_vld[3]); end
    checks++; if (cap_dat[3][0] !== 16'h2000)
      begin errors++; $display("FAIL srst pre lane0 data c3: got %h exp 2000", cap_dat[3][0]); end
    for (int c = 4; c <= 12; c++) begin
      checks++; if (cap_vld[c] !== 4'b0000)
        begin errors++; $display("FAIL srst vld c%0d: got %b exp 0000", c, cap_vld[c]); end
      checks++; if (cap_busy[c] !== 1'b0)
        begin errors++; $display("FAIL srst busy c%0d: got %b exp 0", c, cap_busy[c]); end
      checks++; if (cap_done[c] !== 1'b0)
        begin errors++; $display("FAIL srst done c%0d: got %b exp 0", c, cap_done[c]); end
      checks++; if (cap_rdy[c] !== 1'b0)
        begin errors++; $display("FAIL srst rdy c%0d: got %b exp 0", c, cap_rdy[c]); end
    end
    test_feed(1'b0);
  endtask

  // Tile 1 K=2 (done c8), ignored start in FLUSH at edge 5, tile 2 K=1 started at edge 9.
  task automatic test_back_to_back();
    logic          exp_v;
    logic [DW-1:0] exp_d;
    logic          exp_busy;
    clear_stim();
    st_start[0] = 1'b1; st_k[0] = 10'd2;
    st_vld[2] = 1'b1; st_dat[2] = 16'h0100;
    st_vld[3] = 1'b1; st_dat[3] = 16'h0200;
    st_start[5] = 1'b1; st_k[5] = 10'd5;
    st_start[9] = 1'b1; st_k[9] = 10'd1;
    st_vld[10] = 1'b1; st_dat[10] = 16'h0BAD;
    st_vld[11] = 1'b1; st_dat[11] = 16'h0300;
    run_seq(19);
    for (int c = 1; c <= 19; c++) begin
      exp_busy = (c >= 1 && c <= 8) || (c >= 10 && c <= 16);
      exp_v = (c == 6) || (c == 7) || (c == 15);
      exp_d = (c == 6) ? 16'h0103 : (c == 7) ? 16'h0203 : (c == 15) ? 16'h0303 : 16'h0000;
      checks++; if (cap_clr[c] !== (c == 1 || c == 10))
        begin errors++; $display("FAIL b2b clr c%0d: got %b exp %b", c, cap_clr[c], (c == 1 || c == 10)); end
      checks++; if (cap_done[c] !== (c == 8 || c == 16))
        begin errors++; $display("FAIL b2b done c%0d: got %b exp %b", c, cap_done[c], (c == 8 || c == 16)); end
      checks++; if (cap_rdy[c] !== (c == 2 || c == 3 || c == 11))
        begin errors++; $display("FAIL b2b rdy c%0d: got %b exp %b", c, cap_rdy[c], (c == 2 || c == 3 || c == 11)); end
      checks++; if (cap_busy[c] !== exp_busy)
        begin errors++; $display("FAIL b2b busy c%0d: got %b exp %b", c, cap_busy[c], exp_busy); end
      checks++; if (cap_vld[c][3] !== exp_v)
        begin errors++; $display("FAIL b2b lane3 vld c%0d: got %b exp %b", c, cap_vld[c][3], exp_v); end
      checks++; if (cap_dat[c][3] !== exp_d)
        begin errors++; $display("FAIL b2b lane3 data c%0d: got %h exp %h", c, cap_dat[c][3], exp_d); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_feed(1'b0);
    test_feed(1'b1);
    test_k0();
    test_sync_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
